// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-master data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

   typedef logic master_id_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way picker: round robin on contention, with a bounded
// burst extension for the last winner while it keeps asserting lock.
module dmem_rr_pick
   import dmem_arb_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int CW        = $clog2(MAX_BURST) + 1
) (
   input  logic [1:0]    req,
   input  logic [1:0]    lock,
   input  master_id_t    last,
   input  logic [CW-1:0] burst_cnt,
   output master_id_t    winner,
   output logic          any,
   output logic          extend
);

   always_comb begin
      any    = |req;
      // The last winner may keep the bus only while its run is below the cap
      extend = req[last] && lock[last] && (32'(burst_cnt) < MAX_BURST - 1);
      if (&req) begin
         winner = extend ? last : ~last;
      end else begin
         winner = req[1];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data RAM / MMIO port: grant in IDLE,
// memory access in ISSUE, completion pulse with captured read data in RESP.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_lock,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_done,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_lock,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_done,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(MAX_BURST) + 1;

   arb_state_t    state_q,     state_d;
   master_id_t    cmd_id_q,    cmd_id_d;
   logic          cmd_we_q,    cmd_we_d;
   logic [AW-1:0] cmd_addr_q,  cmd_addr_d;
   logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [DW-1:0] rdata_q,     rdata_d;
   master_id_t    last_q,      last_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;

   master_id_t winner;
   logic       any;
   logic       extend;

   dmem_rr_pick #(
      .MAX_BURST (MAX_BURST),
      .CW        (CW)
   ) u_pick (
      .req       ({m1_req, m0_req}),
      .lock      ({m1_lock, m0_lock}),
      .last      (last_q),
      .burst_cnt (burst_cnt_q),
      .winner    (winner),
      .any       (any),
      .extend    (extend)
   );

   always_comb begin
      state_d     = state_q;
      cmd_id_d    = cmd_id_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      rdata_d     = rdata_q;
      last_d      = last_q;
      burst_cnt_d = burst_cnt_q;
      m0_gnt      = 1'b0;
      m1_gnt      = 1'b0;
      m0_done     = 1'b0;
      m1_done     = 1'b0;
      m0_rdata    = '0;
      m1_rdata    = '0;
      mem_we      = 1'b0;

      case (state_q)
         IDLE: begin
            if (any) begin
               state_d     = ISSUE;
               cmd_id_d    = winner;
               cmd_we_d    = winner ? m1_we    : m0_we;
               cmd_addr_d  = winner ? m1_addr  : m0_addr;
               cmd_wdata_d = winner ? m1_wdata : m0_wdata;
               last_d      = winner;
               burst_cnt_d = extend ? burst_cnt_q + CW'(1) : '0;
               m0_gnt      = ~winner;
               m1_gnt      = winner;
            end
         end
         ISSUE: begin
            // Write strobe exists only here, so reset drops it asynchronously
            mem_we  = cmd_we_q;
            rdata_d = mem_rdata;
            state_d = RESP;
         end
         RESP: begin
            m0_done  = ~cmd_id_q;
            m1_done  = cmd_id_q;
            m0_rdata = cmd_id_q ? '0 : rdata_q;
            m1_rdata = cmd_id_q ? rdata_q : '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr  = cmd_addr_q;
   assign mem_wdata = cmd_wdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cmd_id_q    <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rdata_q     <= '0;
         last_q      <= 1'b1;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cmd_id_q    <= cmd_id_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rdata_q     <= rdata_d;
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
   logic [AW-1:0] m0_addr = '0;
   logic [DW-1:0] m0_wdata = '0;
   logic          m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
   logic [AW-1:0] m1_addr = '0;
   logic [DW-1:0] m1_wdata = '0;
   logic          m0_gnt, m0_done, m1_gnt, m1_done;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_val(input int i);
      return (i == 4) ? 32'h0000_CAFE : (32'hA000_0000 | 32'(i));
   endfunction

   // Bench RAM: combinational read, write on the edge while mem_we is high
   logic [DW-1:0] ram [0:255];
   logic          ram_init;
   assign mem_rdata = ram[mem_addr[9:2]];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      end else if (mem_we) begin
         ram[mem_addr[9:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- transaction-level model + per-cycle compare ----------------
   logic [DW-1:0] mram [0:255];
   bit            minit = 0;
   bit            pv = 0;
   int            pt, pw, free_c = 0, mlast = 1, mcnt = 0;
   bit            pwe;
   logic [AW-1:0] pa;
   logic [DW-1:0] pd, prd;

   int            g_who[$], g_cyc[$], d_cyc[$];
   logic [DW-1:0] d_dat[$];

   always @(negedge clk) begin
      logic [1:0] eg, ed, rq;
      logic       ewe;
      bit         ext;
      int         w;
      if (!minit) begin
         for (int i = 0; i < 256; i++) mram[i] = init_val(i);
         minit = 1;
      end
      if (!reset) begin
         chk("rst_gnt",   {m1_gnt, m0_gnt}, 0);
         chk("rst_done",  {m1_done, m0_done}, 0);
         chk("rst_we",    mem_we, 0);
         chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
         chk("rst_addr",  mem_addr, 0);
         pv = 0; free_c = 0; mlast = 1; mcnt = 0;
      end else begin
         eg = 0; ed = 0; ewe = 0;
         if (pv && cyc == pt + 1) begin
            ewe = pwe;
            chk("acc_addr", mem_addr, pa);
            if (pwe) chk("acc_wdata", mem_wdata, pd);
            prd = mram[pa[9:2]];
            if (pwe) mram[pa[9:2]] = pd;
         end
         if (pv && cyc == pt + 2) begin
            ed[pw] = 1'b1;
            if (!pwe) chk(pw ? "m1_rdata" : "m0_rdata", pw ? m1_rdata : m0_rdata, prd);
            pv = 0;
         end
         rq = {m1_req, m0_req};
         if (!pv && cyc >= free_c && rq != 2'b00) begin
            ext = (mlast ? (m1_req && m1_lock) : (m0_req && m0_lock)) && (mcnt < MB - 1);
            if (rq == 2'b11) w = ext ? mlast : 1 - mlast;
            else             w = int'(rq[1]);
            mcnt   = ext ? mcnt + 1 : 0;
            mlast  = w;
            eg[w]  = 1'b1;
            pv     = 1; pt = cyc; free_c = cyc + 3; pw = w;
            pwe    = w ? m1_we : m0_we;
            pa     = w ? m1_addr : m0_addr;
            pd     = w ? m1_wdata : m0_wdata;
         end
         chk("gnt",    {m1_gnt, m0_gnt}, eg);
         chk("done",   {m1_done, m0_done}, ed);
         chk("mem_we", mem_we, ewe);
         if (m0_gnt) begin g_who.push_back(0); g_cyc.push_back(cyc); end
         if (m1_gnt) begin g_who.push_back(1); g_cyc.push_back(cyc); end
         if (m0_done) begin d_cyc.push_back(cyc); d_dat.push_back(m0_rdata); end
         if (m1_done) begin d_cyc.push_back(cyc); d_dat.push_back(m1_rdata); end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      g_who.delete(); g_cyc.delete(); d_cyc.delete(); d_dat.delete();
   endtask

   task automatic do_reset();
      reset = 1'b0; tick(); tick(); reset = 1'b1;
   endtask

   // Raise a request, wait for its grant, then drop it just after the grant edge
   task automatic issue(input int m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit seen = 0;
      if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
      else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = (m == 0) ? m0_gnt : m1_gnt;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL issue_timeout: master %0d got no gnt", m); end
      tick();
      m0_req = 0; m1_req = 0;
   endtask

   initial begin
      ram_init = 1'b1;
      reset = 1'b1;
      #2 reset = 1'b0;
      @(negedge clk);
      chk("reset_gnt_lit", {m1_gnt, m0_gnt, mem_we}, 0);
      tick();
      ram_init = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      // 1: m0 read of 0x10 alone
      issue(0, 0, 32'h10, 0);
      @(negedge clk);
      chk("t1_addr", mem_addr, 32'h10);
      chk("t1_we", mem_we, 0);
      @(negedge clk);
      chk("t1_done", m0_done, 1);
      chk("t1_rdata", m0_rdata, 32'hCAFE);
      tick(); tick();

      // 2: m1 write 0x104 <- 0x3FF
      issue(1, 1, 32'h104, 32'h3FF);
      @(negedge clk);
      chk("t2_we", mem_we, 1);
      chk("t2_addr", mem_addr, 32'h104);
      chk("t2_wdata", mem_wdata, 32'h3FF);
      chk("t2_m0_gnt", m0_gnt, 0);
      @(negedge clk);
      chk("t2_we_off", mem_we, 0);
      chk("t2_done", {m1_done, m0_done}, 2'b10);
      tick(); tick();
      chk("t2_ram", ram[8'h41], 32'h3FF);
      m1_we = 0;

      // 3: continuous contention without lock alternates starting with m0
      do_reset(); clear_logs();
      m0_we = 0; m0_addr = 32'h20; m1_we = 0; m1_addr = 32'h24;
      m0_req = 1; m1_req = 1;
      repeat (11) tick();
      m0_req = 0; m1_req = 0;
      repeat (4) tick();
      chk("t3_ngnt", g_who.size(), 4);
      if (g_who.size() == 4) begin
         chk("t3_seq", {g_who[0][1:0], g_who[1][1:0], g_who[2][1:0], g_who[3][1:0]}, 8'b00_01_00_01);
         chk("t3_gap", g_cyc[3] - g_cyc[0], 9);
      end

      // 4: m0 lock burst capped at four grants
      do_reset(); clear_logs();
      m0_lock = 1; m0_req = 1; m1_req = 1;
      repeat (17) tick();
      m0_req = 0; m1_req = 0; m0_lock = 0;
      repeat (4) tick();
      chk("t4_ngnt", g_who.size(), 6);
      if (g_who.size() == 6)
         chk("t4_seq", {g_who[0][0], g_who[1][0], g_who[2][0], g_who[3][0], g_who[4][0], g_who[5][0]},
             6'b000010);

      // 5: reset during the ISSUE cycle of an m0 write
      clear_logs();
      issue(0, 1, 32'h30, 32'h55);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("t5_we_drop", mem_we, 0);
      tick();
      @(negedge clk);
      chk("t5_no_done", m0_done, 0);
      tick();
      reset = 1'b1;
      m0_we = 0; m0_addr = 32'h20;
      m0_req = 1; m1_req = 1;
      @(negedge clk);
      chk("t5_first", {m1_gnt, m0_gnt}, 2'b01);
      tick();
      m0_req = 0; m1_req = 0;
      repeat (4) tick();
      chk("t5_ram", ram[12], init_val(12));
      chk("t5_ndone", d_cyc.size(), 1);

      // 6: back-to-back m0 reads with m1 idle
      clear_logs();
      m0_we = 0; m0_addr = 32'h0; m0_req = 1;
      begin
         bit seen = 0;
         for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = m0_gnt; end
         total++;
         if (!seen) begin bad++; $display("FAIL t6_timeout: no first gnt"); end
      end
      tick();
      m0_addr = 32'h4;
      repeat (3) tick();
      m0_req = 0;
      repeat (4) tick();
      chk("t6_ngnt", g_cyc.size(), 2);
      chk("t6_ndone", d_cyc.size(), 2);
      if (g_cyc.size() == 2 && d_cyc.size() == 2) begin
         chk("t6_gap", g_cyc[1] - g_cyc[0], 3);
         chk("t6_d0", d_cyc[0] - g_cyc[0], 2);
         chk("t6_d1", d_cyc[1] - g_cyc[0], 5);
         chk("t6_dat0", d_dat[0], 32'hA000_0000);
         chk("t6_dat1", d_dat[1], 32'hA000_0001);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
